// File: rtl/cmatmul_seq_if.sv
// cmatmul_seq_if: handshake bus for cmatmul_seq.
//   start     - one-cycle request to begin a multiply
//   in_*      - element load stream (A row-major, then B row-major)
//   out_*     - result stream C[i][j], row-major
//   busy      - engine not idle
//   done      - one-cycle pulse after the last result is accepted
interface cmatmul_seq_if #(
   parameter int DW = 8,
   parameter int OW = 19
);
   logic                 start;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] in_real;
   logic signed [DW-1:0] in_imag;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [OW-1:0] out_real;
   logic signed [OW-1:0] out_imag;
   logic                 busy;
   logic                 done;
   modport master (
      output start, in_valid, in_real, in_imag, out_ready,
      input  in_ready, out_valid, out_real, out_imag, busy, done
   );
   modport slave (
      input  start, in_valid, in_real, in_imag, out_ready,
      output in_ready, out_valid, out_real, out_imag, busy, done
   );
endinterface

// File: rtl/cmatmul_seq.sv
// cmatmul_seq: sequential NxN complex matrix multiply, one complex MAC per cycle.
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - cmatmul_seq_if slave: load stream in, result stream out, busy/done
module cmatmul_seq #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int OW = 2*DW+1+$clog2(N)
) (
   input logic          clk,
   input logic          rst,
   cmatmul_seq_if.slave bus
);
   localparam int LW = $clog2(N);
   localparam int IW = 2*LW+1;
   localparam int NE = 2*N*N;
   typedef enum logic [1:0] {IDLE, LOAD, COMP, OUT} state_t;
   state_t state, nxt;
   logic [LW-1:0] i, j, k;
   logic [IW-1:0] ld_cnt;
   logic signed [DW-1:0] m_re [NE];
   logic signed [DW-1:0] m_im [NE];
   logic signed [OW-1:0] ar, ai, br, bi, p_re, p_im, s_re, s_im, acc_re, acc_im;
   logic in_hs, out_hs, last_ld, last_k, last_el;
   logic [IW-1:0] a_idx, b_idx;
   function automatic logic signed [OW-1:0] sx(input logic signed [DW-1:0] v);
      return {{(OW-DW){v[DW-1]}}, v};
   endfunction
   // storage holds A in the lower half and B in the upper half, both row-major,
   // so element addresses are plain bit concatenations of the loop indices
   assign a_idx   = {1'b0, i, k};
   assign b_idx   = {1'b1, k, j};
   assign in_hs   = (state == LOAD) && bus.in_valid;
   assign out_hs  = (state == OUT) && bus.out_ready;
   assign last_ld = ld_cnt == IW'(NE-1);
   assign last_k  = k == LW'(N-1);
   assign last_el = (i == LW'(N-1)) && (j == LW'(N-1));
   assign ar      = sx(m_re[a_idx]);
   assign ai      = sx(m_im[a_idx]);
   assign br      = sx(m_re[b_idx]);
   assign bi      = sx(m_im[b_idx]);
   assign p_re    = ar*br - ai*bi;
   assign p_im    = ar*bi + ai*br;
   assign s_re    = (k == '0 ? '0 : acc_re) + p_re;
   assign s_im    = (k == '0 ? '0 : acc_im) + p_im;
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = bus.start ? LOAD : IDLE;
         LOAD:    nxt = (in_hs && last_ld) ? COMP : LOAD;
         COMP:    nxt = last_k ? OUT : COMP;
         default: nxt = out_hs ? (last_el ? IDLE : COMP) : OUT;
      endcase
   end
   always_comb begin
      bus.in_ready  = state == LOAD;
      bus.out_valid = state == OUT;
      bus.busy      = state != IDLE;
   end
   always_ff @(posedge clk) begin
      if (in_hs && !rst) begin
         m_re[ld_cnt] <= bus.in_real;
         m_im[ld_cnt] <= bus.in_imag;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ld_cnt       <= '0;
         i            <= '0;
         j            <= '0;
         k            <= '0;
         acc_re       <= '0;
         acc_im       <= '0;
         bus.out_real <= '0;
         bus.out_imag <= '0;
         bus.done     <= 1'b0;
      end else begin
         bus.done <= out_hs && last_el;
         if (state == IDLE) ld_cnt <= '0;
         if (in_hs) ld_cnt <= ld_cnt + 1'b1;
         if (state == LOAD) begin
            i <= '0;
            j <= '0;
            k <= '0;
         end
         if (state == COMP) begin
            k      <= k + 1'b1;
            acc_re <= s_re;
            acc_im <= s_im;
            if (last_k) begin
               bus.out_real <= s_re;
               bus.out_imag <= s_im;
            end
         end
         // j and i wrap naturally, so the next element restarts at k=0
         if (out_hs) begin
            j <= j + 1'b1;
            if (j == LW'(N-1)) i <= i + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_cmatmul_seq.sv
// tb_cmatmul_seq: randomized self-checking bench for cmatmul_seq against a plain matrix model.
module tb_cmatmul_seq;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int OW = 19;
   localparam int NN = N*N;
   localparam int NE = 2*NN;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   cmatmul_seq_if #(.DW(DW), .OW(OW)) bus();
   cmatmul_seq #(.N(N), .DW(DW), .OW(OW)) dut (.clk(clk), .rst(rst), .bus(bus));
   int checks = 0;
   int failures = 0;
   int ar [N][N], ai [N][N], br [N][N], bi [N][N];
   longint er [NN], ei [NN];
   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   task automatic model();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            longint sr = 0, si = 0;
            for (int x = 0; x < N; x++) begin
               sr += ar[r][x]*br[x][c] - ai[r][x]*bi[x][c];
               si += ar[r][x]*bi[x][c] + ai[r][x]*br[x][c];
            end
            er[r*N+c] = sr;
            ei[r*N+c] = si;
         end
   endtask
   task automatic fill_rand();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ar[r][c] = int'($urandom_range(0, 255)) - 128;
            ai[r][c] = int'($urandom_range(0, 255)) - 128;
            br[r][c] = int'($urandom_range(0, 255)) - 128;
            bi[r][c] = int'($urandom_range(0, 255)) - 128;
         end
   endtask
   task automatic fill_const(input int re, input int im);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ar[r][c] = re; ai[r][c] = im; br[r][c] = re; bi[r][c] = im;
         end
   endtask
   task automatic load(input bit start_mid);
      int idx = 0;
      int n = 0;
      while (idx < NE && n < 2000) begin
         int e, vr, vi;
         bit v;
         @(negedge clk);
         n++;
         v = $urandom_range(0, 3) != 0;
         e = idx % NN;
         vr = idx < NN ? ar[e/N][e%N] : br[e/N][e%N];
         vi = idx < NN ? ai[e/N][e%N] : bi[e/N][e%N];
         bus.start    = start_mid && idx == 10;
         bus.in_valid = v;
         bus.in_real  = DW'(vr);
         bus.in_imag  = DW'(vi);
         if (bus.in_ready && v) idx++;
      end
      if (idx < NE) check("load_timeout", idx, NE);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
   endtask
   task automatic collect(input int hold_first, input bit start_mid, input int stop_at);
      int idx = 0;
      int n = 0;
      int holds = 0;
      bit held = 1'b0;
      bit rdy;
      longint pr = 0, pi = 0;
      while (idx < stop_at) begin
         @(negedge clk);
         n++;
         if (n > 3000) begin
            check("out_timeout", idx, stop_at);
            break;
         end
         bus.start = start_mid && bus.out_valid && idx == 3;
         if (held) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_re", bus.out_real, pr);
            check("hold_im", bus.out_imag, pi);
         end
         if (bus.out_valid) begin
            rdy = (idx == 0 && holds < hold_first) ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (idx == 0 && !rdy) holds++;
            check("in_ready_in_out", bus.in_ready, 0);
            check("done_early", bus.done, 0);
            if (rdy) begin
               check($sformatf("re[%0d]", idx), bus.out_real, er[idx]);
               check($sformatf("im[%0d]", idx), bus.out_imag, ei[idx]);
               idx++;
            end
            held = !rdy;
            pr = bus.out_real;
            pi = bus.out_imag;
         end else begin
            rdy = $urandom_range(0, 1) != 0;
            held = 1'b0;
         end
         bus.out_ready = rdy;
      end
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.start     = 1'b0;
      if (stop_at == NN) begin
         check("done_pulse", bus.done, 1);
         check("busy_after", bus.busy, 0);
         check("valid_after", bus.out_valid, 0);
         @(negedge clk);
         check("done_once", bus.done, 0);
      end
   endtask
   task automatic run(input int hold_first, input bit st_load, input bit st_out, input int stop_at);
      model();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_load", bus.busy, 1);
      load(st_load);
      collect(hold_first, st_out, stop_at);
   endtask
   initial begin
      bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_real = '0; bus.in_imag = '0; bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_out_real", bus.out_real, 0);
      check("rst_out_imag", bus.out_imag, 0);
      rst = 1'b0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ar[r][c] = r == c ? 1 : 0; ai[r][c] = 0;
            br[r][c] = 4*r + c;        bi[r][c] = -1;
         end
      run(0, 0, 0, NN);
      fill_const(1, 1);
      run(0, 0, 0, NN);
      fill_const(-128, -128);
      run(0, 0, 0, NN);
      fill_rand();
      run(5, 0, 0, NN);
      fill_rand();
      run(0, 0, 0, 6);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", bus.busy, 0);
      check("abort_valid", bus.out_valid, 0);
      check("abort_done", bus.done, 0);
      repeat (40) begin
         @(negedge clk);
         if (bus.out_valid || bus.done) check("abort_quiet", {bus.out_valid, bus.done}, 0);
      end
      fill_rand();
      run(0, 0, 0, NN);
      fill_rand();
      run(0, 1, 1, NN);
      repeat (3) begin
         fill_rand();
         run(0, 0, 0, NN);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cmatmul_seq.md
CMATMUL_SEQ -- requirements
Module: cmatmul_seq

Interface
REQ-001 SHALL have parameter N, default 4, matrix dimension; legal values are powers of two, 2 to 16.
REQ-002 SHALL have parameter DW, default 8, signed width of each real and imaginary input component.
REQ-003 SHALL have parameter OW, default 2*DW+1+log2(N) (19 for defaults), signed width of each output component.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, one-cycle request to begin a multiply.
REQ-007 SHALL have port in_valid, input, 1, input element is valid.
REQ-008 SHALL have port in_ready, output, 1, block accepts an input element.
REQ-009 SHALL have port in_real, input, DW, signed real part of the input element.
REQ-010 SHALL have port in_imag, input, DW, signed imaginary part of the input element.
REQ-011 SHALL have port out_valid, output, 1, result element is valid.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-013 SHALL have port out_real, output, OW, signed real part of C[i][j].
REQ-014 SHALL have port out_imag, output, OW, signed imaginary part of C[i][j].
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 SHALL have port done, output, 1, one-cycle pulse after the last result is accepted.

Function
REQ-017 SHALL compute complex C = A x B with one complex multiply-accumulate per cycle: re += ar*br - ai*bi; im += ar*bi + ai*br.
REQ-018 SHALL store A and B as 2*N*N complex registers, with no external memory.
REQ-019 SHALL implement FSM states IDLE, LOAD, COMP and OUT.
REQ-020 SHALL transition IDLE->LOAD on start=1; start in any other state is ignored.
REQ-021 SHALL drive in_ready=1 only in LOAD; each cycle with in_valid&&in_ready stores one element.
REQ-022 SHALL load order A row-major, then B row-major: 2*N*N handshakes total, with stalls allowed between them.
REQ-023 SHALL enter COMP with i=j=k=0 on the cycle after the 2*N*N-th handshake.
REQ-024 SHALL clear the accumulator on k=0 of each C element and accumulate A[i][k]*B[k][j] on cycle k, for k=0..N-1.
REQ-025 SHALL, after k=N-1, register the full-precision sum onto out_real/out_imag and enter OUT; COMP lasts exactly N cycles per element.
REQ-026 SHALL sign-extend every product and sum to OW bits; no saturation or truncation, since OW is sized for worst case.
REQ-027 SHALL drive out_valid=1 only in OUT and hold out_real/out_imag stable while out_valid=1 and out_ready=0.
REQ-028 SHALL, on an out_valid&&out_ready handshake with (i,j) != (N-1,N-1), advance j (j wraps to 0 and increments i) and return to COMP.
REQ-029 SHALL, on the handshake for (N-1,N-1), go to IDLE and pulse done=1 in that next cycle.
REQ-030 SHALL emit results in row-major order; minimum spacing between results is N+1 cycles.
REQ-031 SHALL leave A/B registers unchanged after done; a new start performs a full reload.

Reset
REQ-032 SHALL, while rst=1 at a clock edge, set state=IDLE, set all counters to 0, and drive in_ready=0, out_valid=0, busy=0, done=0, out_real=0, out_imag=0.
REQ-033 SHALL abort any operation on rst asserted mid-LOAD/COMP/OUT, with no further output handshakes or done pulse.
REQ-034 SHALL treat rst with priority over start and over all handshakes in the same cycle.
REQ-035 SHALL leave A/B storage contents undefined after reset; no reset of storage is required.

Verification
REQ-036 SHALL pass: N=4, A=identity (1+0i on diagonal), B[r][c]=(4r+c)+(-1)i -> 16 outputs equal to B, sign-extended, row-major order.
REQ-037 SHALL pass: all A and B elements 1+1i -> every output re=0, im=8; done pulses once, on the cycle after the 16th handshake.
REQ-038 SHALL pass: all A and B elements -128-128i -> every output re=0, im=131072, with no overflow in 19 bits.
REQ-039 SHALL pass: out_ready held low 5 cycles on the first result -> out_valid stays 1, data stable, no COMP progress; the sequence then resumes.
REQ-040 SHALL pass: rst pulsed during COMP of C[1][2] -> next cycle IDLE with busy=0 and out_valid=0; a new start plus 32 loads yields correct results.
REQ-041 SHALL pass: start pulsed during LOAD and during OUT -> ignored, with load count and outputs unaffected.
